// File: rtl/seq_detect_ctrl_if.sv
// Command/config/stream bundle for seq_detect_ctrl.
// The master drives config, commands and serial data; the slave returns status.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               data_valid;
  logic               data;
  logic               busy;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, data_valid, data,
    input  cfg_err, busy, match_pulse, match_cnt, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, data_valid, data,
    output cfg_err, busy, match_pulse, match_cnt, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector.
// Holds run-time config, arms on start, counts matches and stops at the target.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W:0] MAX_LEN_W = (LEN_W+1)'(MAX_LEN);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_cfg_err;
  logic               r_busy;
  logic               r_match_pulse;
  logic [CNT_W-1:0]   r_match_cnt;
  logic               r_done;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_aligned;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_shamt;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_hit;
  logic               w_len_ok;
  logic               w_cfg_open;

  // Newest bit enters at the MSB, so after shifting down by MAX_LEN-len the
  // oldest of the last len bits lands on bit 0, lining up with pattern[0].
  always_comb begin
    w_hist_next = {bus.data, r_hist[MAX_LEN-1:1]};
    w_shamt     = MAX_LEN_W - {1'b0, r_len};
    w_aligned   = w_hist_next >> w_shamt;
    w_mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
    w_fill_inc  = (r_fill == r_len) ? r_fill : r_fill + LEN_W'(1);
    w_hit       = (w_fill_inc == r_len) && (((w_aligned ^ r_pattern) & w_mask) == '0);
    w_cnt_inc   = (r_match_cnt == '1) ? r_match_cnt : r_match_cnt + CNT_W'(1);
    w_len_ok    = (bus.cfg_len != '0) && ({1'b0, bus.cfg_len} <= MAX_LEN_W);
    w_cfg_open  = (r_state == IDLE) || (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pattern     <= '0;
      r_len         <= LEN_W'(1);
      r_overlap     <= 1'b0;
      r_target      <= '0;
      r_hist        <= '0;
      r_fill        <= '0;
      r_cfg_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_match_pulse <= 1'b0;
      r_match_cnt   <= '0;
      r_done        <= 1'b0;
    end else begin
      r_cfg_err     <= 1'b0;
      r_match_pulse <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        if (bus.cfg_valid) begin
          if (w_cfg_open && w_len_ok) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= bus.cfg_len;
            r_overlap <= bus.cfg_overlap;
            r_target  <= bus.cfg_target;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
        case (r_state)
          IDLE, DONE: begin
            if (bus.start) begin
              r_state     <= ARMED;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_match_cnt <= '0;
              r_hist      <= '0;
              r_fill      <= '0;
            end
          end
          ARMED, RUN: begin
            if (bus.data_valid) begin
              r_state <= RUN;
              r_hist  <= w_hist_next;
              r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
              if (w_hit) begin
                r_match_pulse <= 1'b1;
                r_match_cnt   <= w_cnt_inc;
                if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_err     = r_cfg_err;
  assign bus.busy        = r_busy;
  assign bus.match_pulse = r_match_pulse;
  assign bus.match_cnt   = r_match_cnt;
  assign bus.done        = r_done;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for serial pattern detection. It accepts a programmable pattern, length, overlap mode and match target, then arms on start and scans a valid-qualified serial bit stream. It counts matches and stops when the target count is reached. It sits between a register/command interface and the serial input, and replaces fixed-parameter detectors wherever the pattern must change at run time.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..32)
LEN_W, 5, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
cfg_valid  input  1  configuration write request
cfg_pattern  input  MAX_LEN  pattern; bit 0 is the first serial bit, bit cfg_len-1 is the last
cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after each match
cfg_target  input  CNT_W  matches needed before done; 0 = run until abort
cfg_err  output  1  one-cycle pulse when a config write is rejected
start  input  1  arm the detector (pulse)
abort  input  1  return to IDLE (pulse)
data_valid  input  1  qualifies data
data  input  1  serial bit
busy  output  1  high in ARMED or RUN
match_pulse  output  1  one-cycle pulse per detected match
match_cnt  output  CNT_W  matches since last start; saturates at all-ones
done  output  1  level, high in DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; config registers hold pattern=0, len=1, overlap=0, target=0; history and fill counter cleared.
- States: IDLE, ARMED, RUN, DONE.
- Configuration:
  - A config write is accepted only in IDLE or DONE, when cfg_valid=1 and 1<=cfg_len<=MAX_LEN.
  - A write with an illegal length, or any write made in ARMED/RUN, is ignored and pulses cfg_err on the next cycle.
  - Config registers stay stable for the whole run.
- Transitions:
  - IDLE/DONE -> ARMED on start: clear match_cnt, history and fill counter; deassert done.
  - ARMED -> RUN on the first accepted bit (data_valid=1). ARMED is purely the waiting-for-data state.
  - RUN -> DONE on the cycle a match makes the count equal to cfg_target (cfg_target != 0).
  - Any state -> IDLE on abort. abort has priority over start, cfg_valid and data in the same cycle. match_cnt keeps its value after abort; done clears.
  - A start received in ARMED or RUN is ignored.
- Matching:
  - Each data_valid=1 cycle in ARMED/RUN shifts data into a MAX_LEN history and increments a fill counter, which saturates at cfg_len.
  - A match occurs when the fill counter (including the current bit) reaches cfg_len and the last cfg_len bits, in arrival order, equal cfg_pattern[0..cfg_len-1].
  - Bits with data_valid=0 are skipped; they do not break a partial sequence.
- Match output timing:
  - match_pulse is registered: it is high exactly one cycle after the edge on which the completing bit was sampled.
  - match_cnt updates on the same edge, incrementing by 1 and saturating at 2^CNT_W-1.
- Overlap rule: with cfg_overlap=1 the fill counter is unchanged after a match. With cfg_overlap=0 it resets to 0, so the next match needs cfg_len fresh bits.
- DONE: further data is ignored; no match_pulse is produced.
- Concurrency:
  - data is processed in the same cycle as a state entry only for ARMED -> RUN.
  - The bit that triggers DONE is counted.
  - A start in the same cycle as the transition into DONE is ignored.

Test Plan:
- Config: pattern=4'b1001 (first bit=1), len=4, overlap=0, target=0. start, then stream 1,0,0,1,0,0,1 -> one match_pulse one cycle after bit 4; match_cnt=1. The second 1,0,0,1 shares its first bit with the first match, so no second pulse.
- Same stream with overlap=1 -> pulses after bit 4 and bit 7; match_cnt=2.
- pattern=3'b101, len=3, overlap=1, target=2. Stream 1,0,1,0,1,0,1 -> pulses after bits 3 and 5; done=1 and busy=0 after bit 5; later bits produce no pulse; match_cnt stays 2.
- Valid gaps: pattern 1001, interleave data_valid=0 cycles carrying data=1 between every bit -> still exactly one match.
- Config errors: cfg_len=0 in IDLE, then cfg_len=17 with MAX_LEN=16, then any write during RUN -> cfg_err pulses each time; config unchanged (verify by a subsequent match on the old pattern).
- abort asserted together with start and a completing bit in RUN -> state IDLE next cycle, no match_pulse, done=0. Also assert rst mid-RUN -> all outputs 0 immediately (asynchronous), with no clock edge required.
